// File: rtl/advanced_fifo_pkg.sv
// Shared sizing helpers and the per-cycle operation encoding for advanced_fifo.
package advanced_fifo_pkg;

    // Index width that never collapses to zero bits for tiny depths.
    function automatic int fifo_clog2(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

    // Accepted operation in a cycle, encoded as {push, pop}.
    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_t;

endpackage

// File: rtl/advanced_fifo_controller.sv
// Pointer, level, flag and error-pulse bookkeeping for advanced_fifo; drives the RAM ports.
module advanced_fifo_controller
    import advanced_fifo_pkg::*;
#(
    parameter int DEPTH                  = 4,
    parameter int ALMOST_FULL_THRESHOLD  = DEPTH - 1,
    parameter int ALMOST_EMPTY_THRESHOLD = 1,
    parameter int PTR_W                  = fifo_clog2(DEPTH),
    parameter int LEVEL_W                = fifo_clog2(DEPTH + 1)
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               flush,
    input  logic               write_enable,
    input  logic               read_enable,
    output logic               full,
    output logic               empty,
    output logic               almost_full,
    output logic               almost_empty,
    output logic [LEVEL_W-1:0] level,
    output logic               write_miss,
    output logic               read_error,
    output logic               mem_write_enable,
    output logic [PTR_W-1:0]   mem_write_address,
    output logic [PTR_W-1:0]   mem_read_address
);
    localparam logic [PTR_W-1:0]   LAST_IDX = PTR_W'(DEPTH - 1);
    localparam logic [LEVEL_W-1:0] LVL_FULL = LEVEL_W'(DEPTH);
    localparam logic [LEVEL_W-1:0] LVL_AF   = LEVEL_W'(ALMOST_FULL_THRESHOLD);
    localparam logic [LEVEL_W-1:0] LVL_AE   = LEVEL_W'(ALMOST_EMPTY_THRESHOLD);

    logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
    logic [LEVEL_W-1:0] r_level;
    logic               r_full, r_empty, r_almost_full, r_almost_empty;
    logic               r_write_miss, r_read_error;

    logic               w_push, w_pop;
    fifo_op_t           w_op;
    logic [PTR_W-1:0]   w_wr_ptr_next, w_rd_ptr_next;
    logic [LEVEL_W-1:0] w_level_next;

    // A read frees a slot in the same cycle, so a full FIFO still accepts a paired write.
    assign w_push = write_enable && (!r_full || read_enable);
    assign w_pop  = read_enable && !r_empty;
    assign w_op   = fifo_op_t'({w_push, w_pop});

    always_comb begin
        w_wr_ptr_next = r_wr_ptr;
        w_rd_ptr_next = r_rd_ptr;
        w_level_next  = r_level;
        if (flush) begin
            w_wr_ptr_next = '0;
            w_rd_ptr_next = '0;
            w_level_next  = '0;
        end else begin
            if (w_push) w_wr_ptr_next = (r_wr_ptr == LAST_IDX) ? '0 : r_wr_ptr + 1'b1;
            if (w_pop)  w_rd_ptr_next = (r_rd_ptr == LAST_IDX) ? '0 : r_rd_ptr + 1'b1;
            case (w_op)
                OP_PUSH: w_level_next = r_level + 1'b1;
                OP_POP:  w_level_next = r_level - 1'b1;
                default: w_level_next = r_level;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_level        <= '0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
            r_write_miss   <= 1'b0;
            r_read_error   <= 1'b0;
        end else begin
            r_wr_ptr       <= w_wr_ptr_next;
            r_rd_ptr       <= w_rd_ptr_next;
            r_level        <= w_level_next;
            r_full         <= (w_level_next == LVL_FULL);
            r_empty        <= (w_level_next == '0);
            r_almost_full  <= (w_level_next >= LVL_AF);
            r_almost_empty <= (w_level_next <= LVL_AE);
            r_write_miss   <= !flush && write_enable && !w_push;
            r_read_error   <= !flush && read_enable && r_empty;
        end
    end

    assign mem_write_enable  = w_push && !flush && resetn;
    assign mem_write_address = r_wr_ptr;
    assign mem_read_address  = r_rd_ptr;

    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_almost_full;
    assign almost_empty = r_almost_empty;
    assign level        = r_level;
    assign write_miss   = r_write_miss;
    assign read_error   = r_read_error;

endmodule

// File: rtl/simple_dual_port_ram.sv
// One write port, one read port; read is combinational unless REGISTERED_READ=1.
module simple_dual_port_ram #(
    parameter int WIDTH           = 8,
    parameter int DEPTH           = 4,
    parameter int ADDR_W          = 2,
    parameter bit REGISTERED_READ = 1'b0
) (
    input  logic              clock,
    input  logic              write_enable,
    input  logic [ADDR_W-1:0] write_address,
    input  logic [WIDTH-1:0]  write_data,
    input  logic [ADDR_W-1:0] read_address,
    output logic [WIDTH-1:0]  read_data
);
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clock) begin
        if (write_enable) r_mem[write_address] <= write_data;
    end

    generate
        if (REGISTERED_READ) begin : g_reg_read
            logic [WIDTH-1:0] r_read_data;
            always_ff @(posedge clock) r_read_data <= r_mem[read_address];
            assign read_data = r_read_data;
        end else begin : g_comb_read
            assign read_data = r_mem[read_address];
        end
    endgenerate

endmodule

// File: rtl/advanced_fifo.sv
// First-word fall-through FIFO with level, almost flags, flush and error pulses.
module advanced_fifo
    import advanced_fifo_pkg::*;
#(
    parameter int WIDTH                  = 8,
    parameter int DEPTH                  = 4,
    parameter int ALMOST_FULL_THRESHOLD  = DEPTH - 1,
    parameter int ALMOST_EMPTY_THRESHOLD = 1
) (
    input  logic                            clock,
    input  logic                            resetn,
    input  logic                            flush,
    input  logic                            write_enable,
    input  logic [WIDTH-1:0]                write_data,
    input  logic                            read_enable,
    output logic [WIDTH-1:0]                read_data,
    output logic                            full,
    output logic                            empty,
    output logic                            almost_full,
    output logic                            almost_empty,
    output logic [fifo_clog2(DEPTH+1)-1:0]  level,
    output logic                            write_miss,
    output logic                            read_error
);
    localparam int DEPTH_LOG2  = fifo_clog2(DEPTH);
    localparam int LEVEL_WIDTH = fifo_clog2(DEPTH + 1);

    logic                  w_mem_we;
    logic [DEPTH_LOG2-1:0] w_mem_waddr, w_mem_raddr;

    advanced_fifo_controller #(
        .DEPTH                  (DEPTH),
        .ALMOST_FULL_THRESHOLD  (ALMOST_FULL_THRESHOLD),
        .ALMOST_EMPTY_THRESHOLD (ALMOST_EMPTY_THRESHOLD),
        .PTR_W                  (DEPTH_LOG2),
        .LEVEL_W                (LEVEL_WIDTH)
    ) u_ctrl (
        .clock             (clock),
        .resetn            (resetn),
        .flush             (flush),
        .write_enable      (write_enable),
        .read_enable       (read_enable),
        .full              (full),
        .empty             (empty),
        .almost_full       (almost_full),
        .almost_empty      (almost_empty),
        .level             (level),
        .write_miss        (write_miss),
        .read_error        (read_error),
        .mem_write_enable  (w_mem_we),
        .mem_write_address (w_mem_waddr),
        .mem_read_address  (w_mem_raddr)
    );

    simple_dual_port_ram #(
        .WIDTH           (WIDTH),
        .DEPTH           (DEPTH),
        .ADDR_W          (DEPTH_LOG2),
        .REGISTERED_READ (1'b0)
    ) u_ram (
        .clock         (clock),
        .write_enable  (w_mem_we),
        .write_address (w_mem_waddr),
        .write_data    (write_data),
        .read_address  (w_mem_raddr),
        .read_data     (read_data)
    );

endmodule

// File: tb/tb_advanced_fifo.sv
// Directed bench for advanced_fifo with WIDTH=8, DEPTH=5, AF=4, AE=1.
module tb_advanced_fifo;
    logic       clock = 1'b0;
    logic       resetn, flush, write_enable, read_enable;
    logic [7:0] write_data, read_data;
    logic       full, empty, almost_full, almost_empty, write_miss, read_error;
    logic [2:0] level;

    int checks   = 0;
    int failures = 0;

    advanced_fifo #(
        .WIDTH(8), .DEPTH(5), .ALMOST_FULL_THRESHOLD(4), .ALMOST_EMPTY_THRESHOLD(1)
    ) dut (
        .clock(clock), .resetn(resetn), .flush(flush),
        .write_enable(write_enable), .write_data(write_data),
        .read_enable(read_enable), .read_data(read_data),
        .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .level(level), .write_miss(write_miss), .read_error(read_error)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        write_enable = 1'b0;
        read_enable  = 1'b0;
        flush        = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; idle(); write_data = 8'h00;
        step(); step();
        checks++;
        if ({level, empty, full, almost_full, almost_empty, write_miss, read_error} !== {3'd0, 6'b100100}) begin
            failures++;
            $display("FAIL reset got lvl=%0d e=%b f=%b af=%b ae=%b wm=%b re=%b exp lvl=0 e=1 f=0 af=0 ae=1 wm=0 re=0",
                     level, empty, full, almost_full, almost_empty, write_miss, read_error);
        end
        resetn = 1'b1;
        step();
    endtask

    task automatic test_fill();
        logic [7:0] vals [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        logic [5:0] exp_flags [5] = '{
            {3'd1, 1'b1, 1'b0, 1'b0}, {3'd2, 1'b0, 1'b0, 1'b0}, {3'd3, 1'b0, 1'b0, 1'b0},
            {3'd4, 1'b0, 1'b1, 1'b0}, {3'd5, 1'b0, 1'b1, 1'b1}};
        for (int i = 0; i < 5; i++) begin
            write_enable = 1'b1; write_data = vals[i];
            step();
            checks++;
            if ({level, almost_empty, almost_full, full} !== exp_flags[i]) begin
                failures++;
                $display("FAIL fill[%0d] got {lvl,ae,af,f}=%b exp=%b", i,
                         {level, almost_empty, almost_full, full}, exp_flags[i]);
            end
        end
        idle();
    endtask

    task automatic test_overflow_drain();
        logic [7:0] vals [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        write_enable = 1'b1; write_data = 8'h66;
        step();
        checks++;
        if (write_miss !== 1'b1 || level !== 3'd5) begin
            failures++;
            $display("FAIL overflow got wm=%b lvl=%0d exp wm=1 lvl=5", write_miss, level);
        end
        idle();
        step();
        checks++;
        if (write_miss !== 1'b0) begin
            failures++;
            $display("FAIL overflow_clear got wm=%b exp 0", write_miss);
        end
        read_enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (read_data !== vals[i]) begin
                failures++;
                $display("FAIL drain[%0d] got=%h exp=%h", i, read_data, vals[i]);
            end
            step();
        end
        idle();
        checks++;
        if (empty !== 1'b1 || level !== 3'd0 || read_error !== 1'b0) begin
            failures++;
            $display("FAIL drain_empty got e=%b lvl=%0d re=%b exp e=1 lvl=0 re=0", empty, level, read_error);
        end
    endtask

    task automatic test_wrap();
        // Two words of lead, then paired push/pop, so level holds at 2 across the wrap.
        for (int c = 0; c < 14; c++) begin
            write_enable = (c < 12);
            write_data   = 8'(c + 1);
            read_enable  = (c >= 2);
            if (c >= 2) begin
                checks++;
                if (read_data !== 8'(c - 1)) begin
                    failures++;
                    $display("FAIL wrap[%0d] got=%h exp=%h", c, read_data, 8'(c - 1));
                end
            end
            step();
            if (c == 7) begin
                checks++;
                if (level !== 3'd2) begin
                    failures++;
                    $display("FAIL wrap_level got=%0d exp=2", level);
                end
            end
        end
        idle();
        checks++;
        if (empty !== 1'b1) begin
            failures++;
            $display("FAIL wrap_empty got=%b exp=1", empty);
        end
    endtask

    task automatic test_full_rw();
        logic [7:0] expq [5] = '{8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hAA};
        for (int i = 0; i < 5; i++) begin
            write_enable = 1'b1; write_data = 8'hA1 + 8'(i);
            step();
        end
        write_enable = 1'b1; write_data = 8'hAA; read_enable = 1'b1;
        checks++;
        if (read_data !== 8'hA1) begin
            failures++;
            $display("FAIL full_rw_head got=%h exp=a1", read_data);
        end
        step();
        idle();
        checks++;
        if (level !== 3'd5 || full !== 1'b1 || write_miss !== 1'b0) begin
            failures++;
            $display("FAIL full_rw got lvl=%0d f=%b wm=%b exp lvl=5 f=1 wm=0", level, full, write_miss);
        end
        read_enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (read_data !== expq[i]) begin
                failures++;
                $display("FAIL full_rw_drain[%0d] got=%h exp=%h", i, read_data, expq[i]);
            end
            step();
        end
        idle();
    endtask

    task automatic test_empty_rw();
        logic exp_re [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        write_enable = 1'b1; write_data = 8'h77; read_enable = 1'b1;
        step();
        idle();
        checks++;
        if (read_error !== 1'b1 || level !== 3'd1 || empty !== 1'b0 || read_data !== 8'h77) begin
            failures++;
            $display("FAIL empty_rw got re=%b lvl=%0d e=%b rd=%h exp re=1 lvl=1 e=0 rd=77",
                     read_error, level, empty, read_data);
        end
        // Pop the word, then two reads on empty give back-to-back pulses.
        for (int i = 0; i < 4; i++) begin
            read_enable = (i < 3);
            step();
            checks++;
            if (read_error !== exp_re[i]) begin
                failures++;
                $display("FAIL read_error_seq[%0d] got=%b exp=%b", i, read_error, exp_re[i]);
            end
        end
        idle();
    endtask

    task automatic test_flush_reset();
        for (int i = 0; i < 3; i++) begin
            write_enable = 1'b1; write_data = 8'hC0 + 8'(i);
            step();
        end
        flush = 1'b1; write_enable = 1'b1; write_data = 8'h99;
        step();
        idle();
        checks++;
        if (level !== 3'd0 || empty !== 1'b1 || write_miss !== 1'b0 || almost_empty !== 1'b1) begin
            failures++;
            $display("FAIL flush got lvl=%0d e=%b wm=%b ae=%b exp lvl=0 e=1 wm=0 ae=1",
                     level, empty, write_miss, almost_empty);
        end
        for (int i = 0; i < 4; i++) begin
            write_enable = 1'b1; write_data = 8'hD0 + 8'(i);
            step();
        end
        checks++;
        if (level !== 3'd4 || almost_full !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset got lvl=%0d af=%b exp lvl=4 af=1", level, almost_full);
        end
        resetn = 1'b0; write_enable = 1'b1; read_enable = 1'b1; write_data = 8'hEE;
        step();
        checks++;
        if ({level, empty, full, almost_full, almost_empty, write_miss, read_error} !== {3'd0, 6'b100100}) begin
            failures++;
            $display("FAIL mid_reset got lvl=%0d e=%b f=%b af=%b ae=%b wm=%b re=%b exp lvl=0 e=1 f=0 af=0 ae=1 wm=0 re=0",
                     level, empty, full, almost_full, almost_empty, write_miss, read_error);
        end
        resetn = 1'b1; idle();
        write_enable = 1'b1; write_data = 8'h5A;
        step();
        idle();
        checks++;
        if (read_data !== 8'h5A || level !== 3'd1) begin
            failures++;
            $display("FAIL post_reset got rd=%h lvl=%0d exp rd=5a lvl=1", read_data, level);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fill();
        test_overflow_drain();
        test_wrap();
        test_full_rw();
        test_empty_rw();
        test_flush_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
